if_id_stage: RTL and testbench
==============================

Name: if_id_stage

Overview:
Fetch stage plus IF/ID pipeline register for the 64-bit LEGv8 pipeline. It sits directly upstream of the ID/EX register.
- Owns the PC and drives the instruction-memory request/ready handshake.
- Latches the fetched instruction and its PC for decode.
- Detects load-use hazards against the ID/EX stage, stalling fetch and requesting a bubble into ID/EX.
- A taken branch from the M stage flushes the stage and redirects the PC.

Parameters:
PC_WIDTH, 64, width of PC and branch target
INSTR_WIDTH, 32, instruction width
RESET_PC, 64'h0, PC value loaded on reset
PC_STEP, 4, sequential PC increment in bytes

Ports:
CLOCK  input  1  single clock; all state updates on rising edge
RESET  input  1  synchronous, active-high reset
imem_addr  output  PC_WIDTH  fetch address (equals current PC register)
imem_req  output  1  fetch request; 1 whenever RESET is low and state is RUN
imem_rdata  input  INSTR_WIDTH  fetched instruction, valid when imem_ready=1
imem_ready  input  1  instruction memory returns imem_rdata for imem_addr this cycle
idex_memRead  input  1  memRead_out of the ID/EX register
idex_write_reg  input  5  write_reg_out of the ID/EX register
branch_taken  input  1  M-stage branch resolved taken
branch_target  input  PC_WIDTH  redirect address
PC_out  output  PC_WIDTH  PC of the instruction in decode
instruction_out  output  INSTR_WIDTH  instruction in decode
valid_out  output  1  instruction_out is a real instruction
stall_out  output  1  load-use stall active (combinational)
bubble_out  output  1  ID/EX must load zeroed control this cycle (combinational)

Behaviour:
- Reset, synchronous and checked first every edge:
  - PC register <= RESET_PC.
  - PC_out = 0, instruction_out = 0, valid_out = 0.
  - Skid buffer cleared, skid_valid = 0, state <= RUN.
  - stall_out and bubble_out are 0 while RESET=1.
- Hazard, combinational from the current IF/ID contents:
  - rn = instr[9:5], rm = instr[20:16], rt = instr[4:0].
  - hazard = valid_out & idex_memRead & (idex_write_reg != 5'd31) & (idex_write_reg matches rn, rm or rt).
  - stall_out = hazard & ~branch_taken.
- bubble_out = stall_out | branch_taken.
- States: RUN and SKID.
- RUN:
  - No stall, imem_ready=1: IF/ID <= {PC, imem_rdata}, valid_out <= 1, PC <= PC + PC_STEP.
  - No stall, imem_ready=0: valid_out <= 0 (bubble), PC holds.
  - Stall, imem_ready=1: IF/ID holds, PC holds, skid <= {PC, imem_rdata}, state <= SKID.
  - Stall, imem_ready=0: IF/ID and PC hold.
- SKID:
  - imem_req = 0.
  - Stall persists: hold everything.
  - Stall clears: IF/ID <= skid, valid_out <= 1, PC <= skid PC + PC_STEP, state <= RUN.
- branch_taken, in any state, overrides stall:
  - PC <= branch_target, valid_out <= 0, instruction_out <= 0.
  - skid discarded, state <= RUN.
  - Any imem_rdata arriving that cycle is discarded.
- Latency: one cycle from imem_ready to valid decode output. A load-use hazard costs exactly one bubble.
- PC arithmetic wraps modulo 2^PC_WIDTH with no overflow flag.
- Branch, stall and ready all asserted in the same cycle: branch wins.
- RESET asserted mid-stall or in SKID: the reset values above apply, and branch is ignored.

Decomposition:
- Shared pipeline package:
  - XZR_REG = 5'd31.
  - Instruction field bit positions (RN_LSB=5, RM_LSB=16, RT_LSB=0).
  - Fetch state enum {RUN, SKID}.
- One natural sub-module, load_use_detect: purely combinational hazard compare, reusable by verification as a reference model.

Test Plan:
- Reset then ready held 1 for 4 cycles:
  - imem_addr steps 0,4,8,C.
  - PC_out/instruction_out follow one cycle later, valid_out=1.
- LDUR X2 in ID/EX (idex_memRead=1, idex_write_reg=2) and ADD X3,X2,X4 in IF/ID:
  - stall_out=1 and bubble_out=1 for exactly 1 cycle.
  - The PC=0x10 fetch is captured in SKID and issued after the stall without a refetch.
- idex_write_reg=31 with a matching field: no stall.
- branch_taken=1 with target 0x100 during a stall and ready=1:
  - next imem_addr=0x100, valid_out=0, skid discarded.
- imem_ready low for 3 cycles:
  - valid_out=0 for 3 cycles, PC holds, then resumes.
- RESET pulsed while in SKID:
  - all outputs return to reset values, and imem_addr=RESET_PC next cycle.
- PC=0xFFFF_FFFF_FFFF_FFFC plus a fetch: PC wraps to 0.

Source files
------------

// File: rtl/if_id_stage_pkg.sv
// Shared definitions for the LEGv8 fetch / IF-ID stage.
//   XZR_REG           : register number that never creates a dependency
//   RN_LSB/RM_LSB/RT_LSB : LSB positions of the source/target register fields
//   REG_W             : register-number width
//   fetch_state_e     : fetch controller states
package if_id_stage_pkg;

  localparam int unsigned REG_W  = 5;
  localparam logic [REG_W-1:0] XZR_REG = 5'd31;

  localparam int unsigned RN_LSB = 5;
  localparam int unsigned RM_LSB = 16;
  localparam int unsigned RT_LSB = 0;

  typedef enum logic {
    RUN  = 1'b0,
    SKID = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_id_stage_load_use_detect.sv
// Combinational load-use hazard compare.
//   valid       : decode slot holds a real instruction
//   rn, rm, rt  : register fields of the instruction in decode
//   mem_read    : instruction in ID/EX is a load
//   write_reg   : destination register of the instruction in ID/EX
//   hazard      : decode instruction needs the loaded value next cycle
module load_use_detect
  import if_id_stage_pkg::*;
(
  input  logic             valid,
  input  logic [REG_W-1:0] rn,
  input  logic [REG_W-1:0] rm,
  input  logic [REG_W-1:0] rt,
  input  logic             mem_read,
  input  logic [REG_W-1:0] write_reg,
  output logic             hazard
);

  logic field_match;

  always_comb begin
    field_match = (write_reg == rn) || (write_reg == rm) || (write_reg == rt);
    // A load into XZR writes nothing, so it can never feed a consumer.
    hazard = valid && mem_read && (write_reg != XZR_REG) && field_match;
  end

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage plus IF/ID pipeline register for the 64-bit LEGv8 pipeline.
//   CLOCK, RESET          : clock, synchronous active-high reset
//   imem_addr/imem_req    : instruction-memory request (address is the PC)
//   imem_rdata/imem_ready : instruction-memory response for imem_addr
//   idex_memRead, idex_write_reg : ID/EX contents used for load-use detection
//   branch_taken, branch_target  : M-stage redirect
//   PC_out, instruction_out, valid_out : decode-side IF/ID register
//   stall_out  : load-use stall (combinational)
//   bubble_out : ID/EX must load zeroed control this cycle (combinational)
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter int unsigned             PC_WIDTH    = 64,
  parameter int unsigned             INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]     RESET_PC    = '0,
  parameter int unsigned             PC_STEP     = 4
) (
  input  logic                   CLOCK,
  input  logic                   RESET,
  output logic [PC_WIDTH-1:0]    imem_addr,
  output logic                   imem_req,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   imem_ready,
  input  logic                   idex_memRead,
  input  logic [REG_W-1:0]       idex_write_reg,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic [PC_WIDTH-1:0]    PC_out,
  output logic [INSTR_WIDTH-1:0] instruction_out,
  output logic                   valid_out,
  output logic                   stall_out,
  output logic                   bubble_out
);

  localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(PC_STEP);

  fetch_state_e              state_q, state_d;
  logic [PC_WIDTH-1:0]       pc_q, pc_d;
  logic [PC_WIDTH-1:0]       pc_out_q, pc_out_d;
  logic [INSTR_WIDTH-1:0]    instr_q, instr_d;
  logic                      valid_q, valid_d;
  logic [PC_WIDTH-1:0]       skid_pc_q, skid_pc_d;
  logic [INSTR_WIDTH-1:0]    skid_instr_q, skid_instr_d;
  logic                      skid_valid_q, skid_valid_d;

  logic hazard;
  logic stall;

  load_use_detect u_load_use_detect (
    .valid     (valid_q),
    .rn        (instr_q[RN_LSB +: REG_W]),
    .rm        (instr_q[RM_LSB +: REG_W]),
    .rt        (instr_q[RT_LSB +: REG_W]),
    .mem_read  (idex_memRead),
    .write_reg (idex_write_reg),
    .hazard    (hazard)
  );

  always_comb begin
    stall      = !RESET && hazard && !branch_taken;
    stall_out  = stall;
    bubble_out = stall || (!RESET && branch_taken);
    imem_addr  = pc_q;
    imem_req   = !RESET && (state_q == RUN);
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pc_out_d     = pc_out_q;
    instr_d      = instr_q;
    valid_d      = valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    skid_valid_d = skid_valid_q;

    if (branch_taken) begin
      // Redirect wins over stall and over any word returned this cycle.
      pc_d         = branch_target;
      valid_d      = 1'b0;
      instr_d      = '0;
      skid_valid_d = 1'b0;
      state_d      = RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          if (!stall) begin
            if (imem_ready) begin
              pc_out_d = pc_q;
              instr_d  = imem_rdata;
              valid_d  = 1'b1;
              pc_d     = pc_q + STEP;
            end else begin
              valid_d  = 1'b0;
            end
          end else if (imem_ready) begin
            // Park the returned word instead of dropping it, so the
            // stall never forces a refetch.
            skid_pc_d    = pc_q;
            skid_instr_d = imem_rdata;
            skid_valid_d = 1'b1;
            state_d      = SKID;
          end
        end
        SKID: begin
          if (!stall) begin
            pc_out_d     = skid_pc_q;
            instr_d      = skid_instr_q;
            valid_d      = 1'b1;
            pc_d         = skid_pc_q + STEP;
            skid_valid_d = 1'b0;
            state_d      = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      pc_out_q     <= '0;
      instr_q      <= '0;
      valid_q      <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pc_out_q     <= pc_out_d;
      instr_q      <= instr_d;
      valid_q      <= valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  always_comb begin
    PC_out          = pc_out_q;
    instruction_out = instr_q;
    valid_out       = valid_q;
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// transaction-level model of the fetch stream.
module tb_if_id_stage;

  localparam int unsigned PW = 64;
  localparam int unsigned IW = 32;

  logic          CLOCK = 1'b0;
  logic          RESET;
  logic [PW-1:0] imem_addr;
  logic          imem_req;
  logic [IW-1:0] imem_rdata;
  logic          imem_ready;
  logic          idex_memRead;
  logic [4:0]    idex_write_reg;
  logic          branch_taken;
  logic [PW-1:0] branch_target;
  logic [PW-1:0] PC_out;
  logic [IW-1:0] instruction_out;
  logic          valid_out;
  logic          stall_out;
  logic          bubble_out;

  int checks   = 0;
  int failures = 0;

  if_id_stage #(
    .PC_WIDTH    (PW),
    .INSTR_WIDTH (IW),
    .RESET_PC    (64'h0),
    .PC_STEP     (4)
  ) dut (
    .CLOCK           (CLOCK),
    .RESET           (RESET),
    .imem_addr       (imem_addr),
    .imem_req        (imem_req),
    .imem_rdata      (imem_rdata),
    .imem_ready      (imem_ready),
    .idex_memRead    (idex_memRead),
    .idex_write_reg  (idex_write_reg),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .PC_out          (PC_out),
    .instruction_out (instruction_out),
    .valid_out       (valid_out),
    .stall_out       (stall_out),
    .bubble_out      (bubble_out)
  );

  always #5 CLOCK = ~CLOCK;

  // ---------------- reference model ----------------
  // Tracks: next fetch address, the decode slot, and at most one fetched
  // word waiting behind a stall.
  bit            m_init = 0;
  logic [PW-1:0] m_pc;
  bit            m_v;
  logic [PW-1:0] m_pco;
  logic [IW-1:0] m_ins;
  bit            m_pend;
  logic [PW-1:0] m_pend_pc;
  logic [IW-1:0] m_pend_ins;

  function automatic bit model_hazard(input bit v, input logic [IW-1:0] ins,
                                      input logic mr, input logic [4:0] wr);
    logic [4:0] rn, rm, rt;
    rn = ins[9:5];
    rm = ins[20:16];
    rt = ins[4:0];
    return v && mr && (wr != 5'd31) && (wr == rn || wr == rm || wr == rt);
  endfunction

  always @(posedge CLOCK) begin
    bit hz;
    hz = model_hazard(m_v, m_ins, idex_memRead, idex_write_reg);
    if (RESET) begin
      m_init = 1; m_pc = 64'h0; m_v = 0; m_pco = '0; m_ins = '0; m_pend = 0;
    end else if (m_init) begin
      if (branch_taken) begin
        m_pc = branch_target; m_v = 0; m_ins = '0; m_pend = 0;
      end else if (hz) begin
        if (!m_pend && imem_ready) begin
          m_pend = 1; m_pend_pc = m_pc; m_pend_ins = imem_rdata;
        end
      end else if (m_pend) begin
        m_v = 1; m_pco = m_pend_pc; m_ins = m_pend_ins;
        m_pc = m_pend_pc + 64'd4; m_pend = 0;
      end else if (imem_ready) begin
        m_v = 1; m_pco = m_pc; m_ins = imem_rdata; m_pc = m_pc + 64'd4;
      end else begin
        m_v = 0;
      end
    end
  end

  // ---------------- every-cycle compare ----------------
  always @(negedge CLOCK) begin
    bit e_stall, e_bubble, e_req;
    if (m_init) begin
      e_stall  = !RESET && !branch_taken &&
                 model_hazard(m_v, m_ins, idex_memRead, idex_write_reg);
      e_bubble = e_stall || (!RESET && branch_taken);
      e_req    = !RESET && !m_pend;
      checks++;
      if (imem_addr !== m_pc) begin
        failures++; $display("FAIL model_addr t=%0t got=%h want=%h", $time, imem_addr, m_pc);
      end
      checks++;
      if (valid_out !== m_v) begin
        failures++; $display("FAIL model_valid t=%0t got=%b want=%b", $time, valid_out, m_v);
      end
      checks++;
      if (instruction_out !== m_ins) begin
        failures++; $display("FAIL model_instr t=%0t got=%h want=%h", $time, instruction_out, m_ins);
      end
      if (m_v) begin
        checks++;
        if (PC_out !== m_pco) begin
          failures++; $display("FAIL model_pc_out t=%0t got=%h want=%h", $time, PC_out, m_pco);
        end
      end
      checks++;
      if (stall_out !== e_stall || bubble_out !== e_bubble || imem_req !== e_req) begin
        failures++;
        $display("FAIL model_ctrl t=%0t got stall=%b bubble=%b req=%b want %b %b %b",
                 $time, stall_out, bubble_out, imem_req, e_stall, e_bubble, e_req);
      end
    end
  end

  // ---------------- directed literal checks ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLOCK);
    #1;
  endtask

  task automatic drive(input logic rst, input logic rdy, input logic [IW-1:0] rd,
                       input logic mr, input logic [4:0] wr,
                       input logic br, input logic [PW-1:0] tgt);
    RESET = rst; imem_ready = rdy; imem_rdata = rd; idex_memRead = mr;
    idex_write_reg = wr; branch_taken = br; branch_target = tgt;
    #1;
  endtask

  localparam logic [IW-1:0] ADD_X3_X2_X4 = 32'h8B04_0043;
  localparam logic [IW-1:0] XZR_FIELDS   = 32'h0000_03FF;

  initial begin
    // Reset, with branch and hazard-looking inputs that must be ignored.
    drive(1, 1, ADD_X3_X2_X4, 1, 5'd3, 1, 64'h200);
    tick;
    tick;
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_pc_out", PC_out, 64'd0);
    chk("rst_instr", 64'(instruction_out), 64'd0);
    chk("rst_addr", imem_addr, 64'd0);
    chk("rst_bubble", 64'(bubble_out), 64'd0);
    chk("rst_req", 64'(imem_req), 64'd0);

    // Four sequential fetches with ready held.
    for (int unsigned i = 0; i < 4; i++) begin
      drive(0, 1, (i == 3) ? ADD_X3_X2_X4 : 32'h1000_0000 + i, 0, 5'd0, 0, '0);
      chk("seq_addr", imem_addr, 64'(4 * i));
      chk("seq_req", 64'(imem_req), 64'd1);
      tick;
      chk("seq_pc_out", PC_out, 64'(4 * i));
      chk("seq_valid", 64'(valid_out), 64'd1);
    end
    chk("seq_instr3", 64'(instruction_out), 64'(ADD_X3_X2_X4));

    // Load-use: LDUR X2 in ID/EX, ADD X3,X2,X4 in decode, 0x10 returns.
    drive(0, 1, 32'hAAAA_0010, 1, 5'd2, 0, '0);
    chk("lu_stall", 64'(stall_out), 64'd1);
    chk("lu_bubble", 64'(bubble_out), 64'd1);
    tick;
    drive(0, 0, 32'hDEAD_BEEF, 0, 5'd0, 0, '0);
    chk("lu_stall_gone", 64'(stall_out), 64'd0);
    chk("lu_skid_req", 64'(imem_req), 64'd0);
    chk("lu_addr_hold", imem_addr, 64'h10);
    tick;
    chk("lu_issue_pc", PC_out, 64'h10);
    chk("lu_issue_instr", 64'(instruction_out), 64'hAAAA_0010);
    chk("lu_issue_addr", imem_addr, 64'h14);

    // Load into XZR with matching fields: no stall.
    drive(0, 1, XZR_FIELDS, 0, 5'd0, 0, '0);
    tick;
    drive(0, 1, ADD_X3_X2_X4, 1, 5'd31, 0, '0);
    chk("xzr_no_stall", 64'(stall_out), 64'd0);
    tick;

    // Branch together with stall and ready: branch wins.
    drive(0, 1, 32'h5555_5555, 1, 5'd4, 1, 64'h100);
    chk("br_stall", 64'(stall_out), 64'd0);
    chk("br_bubble", 64'(bubble_out), 64'd1);
    tick;
    chk("br_addr", imem_addr, 64'h100);
    chk("br_valid", 64'(valid_out), 64'd0);
    chk("br_instr", 64'(instruction_out), 64'd0);
    chk("br_req", 64'(imem_req), 64'd1);

    // Memory not ready for three cycles.
    for (int unsigned i = 0; i < 3; i++) begin
      drive(0, 0, 32'h0, 0, 5'd0, 0, '0);
      tick;
      chk("nr_valid", 64'(valid_out), 64'd0);
      chk("nr_addr", imem_addr, 64'h100);
    end
    drive(0, 1, ADD_X3_X2_X4, 0, 5'd0, 0, '0);
    tick;
    chk("nr_resume_pc", PC_out, 64'h100);
    chk("nr_resume_addr", imem_addr, 64'h104);

    // Enter SKID, then reset with a branch present.
    drive(0, 1, 32'h7777_7777, 1, 5'd3, 0, '0);
    tick;
    chk("skid_req", 64'(imem_req), 64'd0);
    drive(1, 1, 32'h7777_7777, 1, 5'd3, 1, 64'h200);
    tick;
    chk("skid_rst_valid", 64'(valid_out), 64'd0);
    chk("skid_rst_pc_out", PC_out, 64'd0);
    chk("skid_rst_addr", imem_addr, 64'd0);
    drive(0, 0, 32'h0, 0, 5'd0, 0, '0);
    chk("skid_rst_req", 64'(imem_req), 64'd1);

    // PC wrap.
    drive(0, 0, 32'h0, 0, 5'd0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    tick;
    drive(0, 1, 32'h1234_5678, 0, 5'd0, 0, '0);
    tick;
    chk("wrap_addr", imem_addr, 64'd0);
    chk("wrap_pc_out", PC_out, 64'hFFFF_FFFF_FFFF_FFFC);

    // Randomized traffic; register fields biased toward small numbers so
    // hazards actually occur.
    for (int unsigned n = 0; n < 3000; n++) begin
      logic [IW-1:0] rd;
      logic [4:0]    wr;
      logic [PW-1:0] tgt;
      rd = $urandom;
      rd[9:5]   = 5'($urandom_range(0, 5));
      rd[20:16] = 5'($urandom_range(0, 5));
      rd[4:0]   = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 5));
      wr  = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 5));
      tgt = {$urandom, $urandom};
      tgt[1:0] = 2'b00;
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), rd,
            ($urandom_range(0, 1) == 1), wr, ($urandom_range(0, 9) == 0), tgt);
      tick;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
